mem_stage: RTL and testbench

Memory-access stage of the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the WB stage. It consumes the `_M` control and data signals, runs a req/ready handshake with the data memory, and raises `stall_M` while an access is outstanding. It contains the MEM/WB pipeline register, which drives the `_W` signals, and it reports misaligned, illegal and timed-out accesses.

---
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage.sv | 136 +++++++++++++
 tb/tb_mem_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory request/ready bus between mem_stage and the data memory

interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ready
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage with dmem handshake, stall, MEM/WB register and error reporting

module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RegWrite_M,
  input  logic               MemToReg_M,
  input  logic               MemWrite_M,
  input  logic               MemRead_M,
  input  logic [31:0]        ALUout_M,
  input  logic [31:0]        WriteData_M,
  input  logic [4:0]         WriteReg_M,
  mem_stage_if.master        dmem,
  output logic               stall_M,
  output logic               RegWrite_W,
  output logic               MemToReg_W,
  output logic [31:0]        ReadData_W,
  output logic [31:0]        ALUout_W,
  output logic [4:0]         WriteReg_W,
  output logic               mem_err,
  output logic [1:0]         err_cause
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_RW_BOTH  = 2'b11;

  logic       state;
  logic [7:0] wait_cnt;

  logic mem_op;
  logic rw_both;
  logic misaligned;
  logic legal_op;
  logic illegal_op;
  logic wait_done;
  logic wait_timeout;

  // Classify the instruction currently sitting in M and the WAIT exit conditions
  always_comb begin
    mem_op       = MemRead_M | MemWrite_M;
    rw_both      = MemRead_M & MemWrite_M;
    misaligned   = ALUout_M[1:0] != 2'b00;
    legal_op     = mem_op & ~rw_both & ~misaligned;
    illegal_op   = mem_op & ~legal_op;
    // ready on the final counted cycle still counts as a normal completion
    wait_done    = (state == ST_WAIT) & dmem.dmem_ready;
    wait_timeout = (state == ST_WAIT) & ~dmem.dmem_ready & (wait_cnt == CNT_LAST);
  end

  // Hold upstream while a request is being launched or is still outstanding
  always_comb begin
    stall_M = 1'b0;
    if (state == ST_IDLE) begin
      stall_M = legal_op;
    end else begin
      stall_M = ~dmem.dmem_ready & (wait_cnt != CNT_LAST);
    end
  end

  // Access FSM, wait counter and registered dmem request fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      wait_cnt        <= 8'd0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'd0;
      dmem.dmem_wdata <= 32'd0;
    end else if (state == ST_IDLE) begin
      if (legal_op) begin
        state           <= ST_WAIT;
        wait_cnt        <= 8'd0;
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= MemWrite_M;
        dmem.dmem_addr  <= ALUout_M;
        dmem.dmem_wdata <= WriteData_M;
      end
    end else begin
      if (wait_done || wait_timeout) begin
        state         <= ST_IDLE;
        dmem.dmem_req <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // One-cycle error pulse; cleared on every edge that does not set it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err   <= 1'b0;
      err_cause <= 2'b00;
    end else if (state == ST_IDLE && illegal_op) begin
      mem_err   <= 1'b1;
      err_cause <= rw_both ? CAUSE_RW_BOTH : CAUSE_MISALIGN;
    end else if (wait_timeout) begin
      mem_err   <= 1'b1;
      err_cause <= CAUSE_TIMEOUT;
    end else begin
      mem_err   <= 1'b0;
      err_cause <= 2'b00;
    end
  end

  // MEM/WB register: pass the instruction on completion, otherwise insert an all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_W <= 1'b0;
      MemToReg_W <= 1'b0;
      ReadData_W <= 32'd0;
      ALUout_W   <= 32'd0;
      WriteReg_W <= 5'd0;
    end else if ((state == ST_IDLE && !mem_op) || wait_done) begin
      RegWrite_W <= RegWrite_M;
      MemToReg_W <= MemToReg_M;
      ReadData_W <= (wait_done && MemRead_M) ? dmem.dmem_rdata : 32'd0;
      ALUout_W   <= ALUout_M;
      WriteReg_W <= WriteReg_M;
    end else begin
      RegWrite_W <= 1'b0;
      MemToReg_W <= 1'b0;
      ReadData_W <= 32'd0;
      ALUout_W   <= 32'd0;
      WriteReg_W <= 5'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage

module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M;
  logic [31:0] ALUout_M, WriteData_M;
  logic [4:0]  WriteReg_M;
  logic        stall_M;
  logic        RegWrite_W, MemToReg_W;
  logic [31:0] ReadData_W, ALUout_W;
  logic [4:0]  WriteReg_W;
  logic        mem_err;
  logic [1:0]  err_cause;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_if mif ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RegWrite_M  (RegWrite_M),
    .MemToReg_M  (MemToReg_M),
    .MemWrite_M  (MemWrite_M),
    .MemRead_M   (MemRead_M),
    .ALUout_M    (ALUout_M),
    .WriteData_M (WriteData_M),
    .WriteReg_M  (WriteReg_M),
    .dmem        (mif.master),
    .stall_M     (stall_M),
    .RegWrite_W  (RegWrite_W),
    .MemToReg_W  (MemToReg_W),
    .ReadData_W  (ReadData_W),
    .ALUout_W    (ALUout_W),
    .WriteReg_W  (WriteReg_W),
    .mem_err     (mem_err),
    .err_cause   (err_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the M-stage fields at the negedge, leaving the comb stall settled for checking
  task automatic drive(input logic rw, input logic m2r, input logic mw, input logic mr,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                       input logic rdy, input logic [31:0] rdata);
    @(negedge clk);
    RegWrite_M     = rw;
    MemToReg_M     = m2r;
    MemWrite_M     = mw;
    MemRead_M      = mr;
    ALUout_M       = alu;
    WriteData_M    = wd;
    WriteReg_M     = wr;
    mif.dmem_ready = rdy;
    mif.dmem_rdata = rdata;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},    32'(mif.dmem_req), 32'd0);
    chk({tag, "_we"},     32'(mif.dmem_we), 32'd0);
    chk({tag, "_addr"},   mif.dmem_addr, 32'd0);
    chk({tag, "_wdata"},  mif.dmem_wdata, 32'd0);
    chk({tag, "_stall"},  32'(stall_M), 32'd0);
    chk({tag, "_rw_w"},   32'(RegWrite_W), 32'd0);
    chk({tag, "_m2r_w"},  32'(MemToReg_W), 32'd0);
    chk({tag, "_rd_w"},   ReadData_W, 32'd0);
    chk({tag, "_alu_w"},  ALUout_W, 32'd0);
    chk({tag, "_wr_w"},   32'(WriteReg_W), 32'd0);
    chk({tag, "_err"},    32'(mem_err), 32'd0);
    chk({tag, "_cause"},  32'(err_cause), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    RegWrite_M     = 1'b0;
    MemToReg_M     = 1'b0;
    MemWrite_M     = 1'b0;
    MemRead_M      = 1'b0;
    ALUout_M       = 32'd0;
    WriteData_M    = 32'd0;
    WriteReg_M     = 5'd0;
    mif.dmem_ready = 1'b0;
    mif.dmem_rdata = 32'd0;

    // reset state
    edge_wait();
    edge_wait();
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU op passes straight through in one cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'hAAAA_5555, 5'd5, 1'b0, 32'd0);
    chk("alu_stall", 32'(stall_M), 32'd0);
    edge_wait();
    chk("alu_rw_w",  32'(RegWrite_W), 32'd1);
    chk("alu_alu_w", ALUout_W, 32'h0000_1234);
    chk("alu_wr_w",  32'(WriteReg_W), 32'd5);
    chk("alu_rd_w",  ReadData_W, 32'd0);
    chk("alu_req",   32'(mif.dmem_req), 32'd0);

    // load 0x100, ready in the 3rd WAIT cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'd0, 5'd7, 1'b0, 32'd0);
    chk("ld_idle_stall", 32'(stall_M), 32'd1);
    chk("ld_idle_req",   32'(mif.dmem_req), 32'd0);
    edge_wait();
    chk("ld_req1",  32'(mif.dmem_req), 32'd1);
    chk("ld_addr",  mif.dmem_addr, 32'h0000_0100);
    chk("ld_we",    32'(mif.dmem_we), 32'd0);
    chk("ld_bub1",  32'(RegWrite_W), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'd0, 5'd7, 1'b0, 32'd0);
    chk("ld_w1_stall", 32'(stall_M), 32'd1);
    edge_wait();
    chk("ld_req2", 32'(mif.dmem_req), 32'd1);
    chk("ld_bub2", 32'(MemToReg_W), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'd0, 5'd7, 1'b0, 32'd0);
    chk("ld_w2_stall", 32'(stall_M), 32'd1);
    edge_wait();
    chk("ld_req3", 32'(mif.dmem_req), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'd0, 5'd7, 1'b1, 32'hDEAD_BEEF);
    chk("ld_w3_stall", 32'(stall_M), 32'd0);
    edge_wait();
    chk("ld_req_off", 32'(mif.dmem_req), 32'd0);
    chk("ld_rd_w",    ReadData_W, 32'hDEAD_BEEF);
    chk("ld_m2r_w",   32'(MemToReg_W), 32'd1);
    chk("ld_rw_w",    32'(RegWrite_W), 32'd1);
    chk("ld_wr_w",    32'(WriteReg_W), 32'd7);
    chk("ld_err",     32'(mem_err), 32'd0);

    // misaligned store 0x102: no request, one error pulse
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h1234_5678, 5'd0, 1'b0, 32'd0);
    chk("mis_stall", 32'(stall_M), 32'd0);
    edge_wait();
    chk("mis_req",   32'(mif.dmem_req), 32'd0);
    chk("mis_err",   32'(mem_err), 32'd1);
    chk("mis_cause", 32'(err_cause), 32'd1);
    chk("mis_rw_w",  32'(RegWrite_W), 32'd0);
    nop();
    edge_wait();
    chk("mis_err_clr", 32'(mem_err), 32'd0);

    // read and write both asserted
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'd0, 5'd3, 1'b0, 32'd0);
    chk("rw_stall", 32'(stall_M), 32'd0);
    edge_wait();
    chk("rw_err",   32'(mem_err), 32'd1);
    chk("rw_cause", 32'(err_cause), 32'd3);
    chk("rw_rw_w",  32'(RegWrite_W), 32'd0);
    chk("rw_req",   32'(mif.dmem_req), 32'd0);

    // timeout with TIMEOUT=4: req high 4 cycles, then cause 10
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'd0, 5'd9, 1'b0, 32'd0);
    edge_wait();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'd0, 5'd9, 1'b0, 32'd0);
      chk($sformatf("to_w%0d_stall", i + 1), 32'(stall_M), 32'd1);
      chk($sformatf("to_w%0d_req", i + 1), 32'(mif.dmem_req), 32'd1);
      edge_wait();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'd0, 5'd9, 1'b0, 32'd0);
    chk("to_w4_stall", 32'(stall_M), 32'd0);
    chk("to_w4_req",   32'(mif.dmem_req), 32'd1);
    chk("to_w4_err",   32'(mem_err), 32'd0);
    edge_wait();
    chk("to_req_off", 32'(mif.dmem_req), 32'd0);
    chk("to_err",     32'(mem_err), 32'd1);
    chk("to_cause",   32'(err_cause), 32'd2);
    chk("to_rw_w",    32'(RegWrite_W), 32'd0);
    nop();
    edge_wait();
    chk("to_err_clr", 32'(mem_err), 32'd0);

    // ready on the final counted WAIT cycle completes normally
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0304, 32'd0, 5'd10, 1'b0, 32'd0);
    edge_wait();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0304, 32'd0, 5'd10, 1'b0, 32'd0);
      edge_wait();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0304, 32'd0, 5'd10, 1'b1, 32'h0000_55AA);
    chk("tr_stall", 32'(stall_M), 32'd0);
    edge_wait();
    chk("tr_err",  32'(mem_err), 32'd0);
    chk("tr_rd_w", ReadData_W, 32'h0000_55AA);
    chk("tr_rw_w", 32'(RegWrite_W), 32'd1);
    chk("tr_req",  32'(mif.dmem_req), 32'd0);

    // back-to-back store 0x200 then load 0x204
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_CAFE, 5'd0, 1'b0, 32'd0);
    edge_wait();
    chk("bb_st_req",   32'(mif.dmem_req), 32'd1);
    chk("bb_st_we",    32'(mif.dmem_we), 32'd1);
    chk("bb_st_addr",  mif.dmem_addr, 32'h0000_0200);
    chk("bb_st_wdata", mif.dmem_wdata, 32'h0000_CAFE);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_CAFE, 5'd0, 1'b1, 32'hFFFF_FFFF);
    chk("bb_st_stall", 32'(stall_M), 32'd0);
    edge_wait();
    chk("bb_st_rd_w", ReadData_W, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0204, 32'd0, 5'd12, 1'b1, 32'hFFFF_FFFF);
    chk("bb_gap_req",   32'(mif.dmem_req), 32'd0);
    chk("bb_gap_stall", 32'(stall_M), 32'd1);
    edge_wait();
    chk("bb_ld_req",  32'(mif.dmem_req), 32'd1);
    chk("bb_ld_addr", mif.dmem_addr, 32'h0000_0204);
    chk("bb_ld_we",   32'(mif.dmem_we), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0204, 32'd0, 5'd12, 1'b1, 32'h0000_1111);
    edge_wait();
    chk("bb_ld_rd_w", ReadData_W, 32'h0000_1111);
    chk("bb_ld_wr_w", 32'(WriteReg_W), 32'd12);

    // reset asserted in WAIT drops the request without a clock edge
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'd0, 5'd4, 1'b0, 32'd0);
    edge_wait();
    chk("rw_wait_req", 32'(mif.dmem_req), 32'd1);
    @(negedge clk);
    rst_n          = 1'b0;
    RegWrite_M     = 1'b0;
    MemToReg_M     = 1'b0;
    MemRead_M      = 1'b0;
    ALUout_M       = 32'd0;
    WriteReg_M     = 5'd0;
    #1;
    chk_all_zero("rstw");
    @(negedge clk);
    rst_n = 1'b1;
    // back in IDLE: ready is ignored and an ALU op flows without stall or error
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0042, 32'd0, 5'd6, 1'b1, 32'h0BAD_0BAD);
    chk("post_stall", 32'(stall_M), 32'd0);
    edge_wait();
    chk("post_err",   32'(mem_err), 32'd0);
    chk("post_alu_w", ALUout_W, 32'h0000_0042);
    chk("post_rd_w",  ReadData_W, 32'd0);
    chk("post_req",   32'(mif.dmem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
